rom_fetch_unit: RTL and testbench
=================================

// Module: rom_fetch_unit
// PURPOSE
//  Sequential byte fetcher sitting directly upstream of the ROM. It drives the ROM address,
//  absorbs the ROM's 1-cycle registered read latency, and delivers a stream of (address, byte)
//  pairs to the decoder over a VALID/READY handshake. It supports jumps (flush plus redirect)
//  and applies back-pressure without losing or duplicating bytes.
// PARAMETERS
//  ADDR_WIDTH  8      ROM address width; the PC wraps modulo 2**ADDR_WIDTH
//  DATA_WIDTH  8      ROM word width
//  FIFO_DEPTH  2      output buffer entries; must be >= 2 to sustain 1 byte/cycle
//  RESET_ADDR  8'h00  PC value after reset
// PORTS
//  CLK         in   1           system clock, rising edge
//  RESET_N     in   1           asynchronous, active-low reset
//  ROM_ADDR    out  ADDR_WIDTH  address to the ROM; always equals the PC register
//  ROM_DATA    in   DATA_WIDTH  ROM output; holds ROM[ROM_ADDR] sampled at the previous edge
//  JUMP_EN     in   1           redirect request, single-cycle pulse
//  JUMP_ADDR   in   ADDR_WIDTH  jump target, sampled when JUMP_EN=1
//  BYTE_OUT    out  DATA_WIDTH  FIFO head data
//  BYTE_ADDR   out  ADDR_WIDTH  ROM address that BYTE_OUT came from
//  BYTE_VALID  out  1           FIFO not empty
//  BYTE_READY  in   1           consumer accepts; pop = BYTE_VALID & BYTE_READY
// BEHAVIOUR
//  - Reset (async assert, sync release): PC=RESET_ADDR, inflight=0, FIFO empty; BYTE_VALID=0,
//    BYTE_OUT=0, BYTE_ADDR=0.
//  - Issue condition, evaluated combinationally:
//    issue = !JUMP_EN & (count + inflight - pop) < FIFO_DEPTH.
//    On an issue edge: PC <= PC+1, with 8'hFF wrapping to 8'h00. inflight <= issue, and
//    inflight_addr <= PC.
//  - Capture: on an edge with inflight=1 and no JUMP_EN, {inflight_addr, ROM_DATA} is written
//    to the FIFO tail.
//  - Latency: issue at edge N -> byte written at edge N+1 -> BYTE_VALID visible after edge N+1.
//    After reset release, the first byte (addr RESET_ADDR) is valid after the 2nd edge.
//  - Throughput: 1 byte/cycle while BYTE_READY=1 continuously, with no bubbles after the
//    initial fill.
//  - Back-pressure: BYTE_OUT, BYTE_ADDR and BYTE_VALID hold stable while VALID & !READY.
//    The credit rule guarantees the in-flight byte always has a FIFO slot, so there is no
//    overflow and no drop.
//  - Simultaneous push and pop: count is unchanged and both pointers advance.
//  - Jump, at an edge with JUMP_EN=1:
//    * PC <= JUMP_ADDR, FIFO flushed (count=0), inflight <= 0.
//    * A pop in the same cycle is ignored; the consumer must treat that byte as discarded.
//    * No issue occurs on the jump edge. JUMP_ADDR is issued at the next edge, and its byte is
//      valid 2 edges after the jump edge.
//    * Back-to-back jumps: the last one wins.
//  - Reset mid-stream: everything returns to its reset values immediately, and the in-flight
//    ROM read is discarded.
// STRUCTURE
//  - Shared package holds: ADDR_WIDTH/DATA_WIDTH defaults and a fetch_entry_t struct
//    {addr, data}.
//  - One sub-module: fetch_fifo, a sync FIFO with a flush input, exposing count, head, push
//    and pop.
//  - The top level holds the PC, inflight/inflight_addr, and the issue/credit logic only.
// TESTING (bench instantiates the existing ROM, preloaded with ROM[i] = i ^ 8'h5A)
//  1. Reset release, READY=1 -> bytes 5A,5B,58,... with BYTE_ADDR=00,01,02,...; first
//     VALID after the 2nd edge, then 1 byte/cycle.
//  2. READY=0 for 5 cycles mid-stream at addr 10 -> BYTE_OUT=4A and BYTE_ADDR=10 held stable.
//     On release the sequence continues from 11 with no gap and no repeat.
//  3. Pulse JUMP_EN with JUMP_ADDR=80 while the FIFO is full -> VALID drops next cycle.
//     Then BYTE_ADDR=80 with BYTE_OUT=DA appears 2 edges after the jump edge, and no
//     pre-jump byte leaks out.
//  4. Jump to FE with READY=1 -> addresses FE,FF,00,01 and data A4,A5,5A,5B (wrap-around).
//  5. JUMP_EN coinciding with a pop, then a second JUMP_EN on the next cycle to 20 -> the
//     stream restarts at 20 (data 7A) only.
//  6. Assert RESET_N=0 asynchronously mid-stream -> VALID=0 immediately.
//     After release the stream restarts at RESET_ADDR, with the same latency as scenario 1.

Source files
------------

// File: rtl/rom_fetch_unit_pkg.sv
// Shared types and width defaults for the ROM fetch unit and its output FIFO.
package rom_fetch_unit_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/rom_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetched (addr, data) entries; flush empties it in one edge.
module fetch_fifo
    import rom_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t           mem [DEPTH];

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rom_fetch_unit.sv
// Sequential ROM byte fetcher: drives the PC, hides the ROM read latency and
// streams (address, byte) pairs to the decoder with jump and back-pressure support.
module rom_fetch_unit
    import rom_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [DATA_WIDTH-1:0] ROM_DATA,
    input  logic                  JUMP_EN,
    input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
    output logic [DATA_WIDTH-1:0] BYTE_OUT,
    output logic [ADDR_WIDTH-1:0] BYTE_ADDR,
    output logic                  BYTE_VALID,
    input  logic                  BYTE_READY
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic [CNT_W-1:0]      count;
    logic [OCC_W-1:0]      occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;
    entry_t                push_entry;
    entry_t                head;

    // Credit check counts the in-flight read so its byte always has a slot.
    always_comb begin
        occupancy  = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        issue      = !JUMP_EN && (occupancy < OCC_W'(FIFO_DEPTH));
        push       = inflight && !JUMP_EN;
        push_entry = '{addr: inflight_addr, data: ROM_DATA};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc            <= RESET_ADDR;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            if (JUMP_EN)
                pc <= JUMP_ADDR;
            else if (issue)
                pc <= pc + 1'b1;
            inflight <= issue;
            if (issue)
                inflight_addr <= pc;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .flush      (JUMP_EN),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign ROM_ADDR   = pc;
    assign BYTE_VALID = (count != '0);
    assign pop        = BYTE_VALID && BYTE_READY;
    assign BYTE_OUT   = head.data;
    assign BYTE_ADDR  = head.addr;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: registered ROM holding i ^ 8'h5A, directed scenarios
// followed by random READY/JUMP traffic checked against a stream-level model.
module tb_rom_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic [7:0] byte_out;
    logic [7:0] byte_addr;
    logic       byte_valid;
    logic       byte_ready;

    logic [7:0] rom [256];

    int errors = 0;
    int checks = 0;

    // Stream model: next address the consumer should see, and edges since restart.
    logic [7:0] exp_addr;
    int         since_restart;

    rom_fetch_unit #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (2),
        .RESET_ADDR (8'h00)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .ROM_ADDR   (rom_addr),
        .ROM_DATA   (rom_data),
        .JUMP_EN    (jump_en),
        .JUMP_ADDR  (jump_addr),
        .BYTE_OUT   (byte_out),
        .BYTE_ADDR  (byte_addr),
        .BYTE_VALID (byte_valid),
        .BYTE_READY (byte_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_stream(input string tag);
        logic pred_valid;
        pred_valid = (since_restart >= 2);
        chk({tag, "_valid"}, 16'(byte_valid), 16'(pred_valid));
        if (pred_valid) begin
            chk({tag, "_addr"}, 16'(byte_addr), 16'(exp_addr));
            chk({tag, "_data"}, 16'(byte_out), 16'(exp_addr ^ 8'h5A));
        end
    endtask

    // Drive one cycle from a negedge, advance the model at the edge, check at the next negedge.
    task automatic cycle(input logic rdy, input logic jmp, input logic [7:0] ja, input string tag);
        logic pred_valid;
        pred_valid = (since_restart >= 2);
        byte_ready = rdy;
        jump_en    = jmp;
        jump_addr  = ja;
        @(posedge clk);
        if (jmp) begin
            exp_addr      = ja;
            since_restart = 0;
        end else begin
            if (pred_valid && rdy)
                exp_addr = exp_addr + 8'd1;
            if (since_restart < 2)
                since_restart++;
        end
        @(negedge clk);
        jump_en = 1'b0;
        check_stream(tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = 8'(i) ^ 8'h5A;
        rst_n         = 1'b0;
        jump_en       = 1'b0;
        jump_addr     = 8'h00;
        byte_ready    = 1'b1;
        exp_addr      = 8'h00;
        since_restart = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 16'(byte_valid), 16'h0);
        chk("rst_out", 16'(byte_out), 16'h0);
        chk("rst_baddr", 16'(byte_addr), 16'h0);
        chk("rst_romaddr", 16'(rom_addr), 16'h0);

        // 1: release, first byte after 2nd edge, then 1/cycle
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h00, "s1_e1");
        chk("s1_e1_novalid", 16'(byte_valid), 16'h0);
        cycle(1'b1, 1'b0, 8'h00, "s1_e2");
        chk("s1_first_addr", 16'(byte_addr), 16'h00);
        chk("s1_first_data", 16'(byte_out), 16'h5A);
        while (exp_addr != 8'h10)
            cycle(1'b1, 1'b0, 8'h00, "s1_run");

        // 2: back-pressure at addr 10
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 8'h00, "s2_hold");
            chk("s2_hold_addr", 16'(byte_addr), 16'h10);
            chk("s2_hold_data", 16'(byte_out), 16'h4A);
        end
        cycle(1'b1, 1'b0, 8'h00, "s2_rel");
        chk("s2_next_addr", 16'(byte_addr), 16'h11);
        repeat (4) cycle(1'b1, 1'b0, 8'h00, "s2_run");

        // 3: jump to 80 with FIFO full
        repeat (3) cycle(1'b0, 1'b0, 8'h00, "s3_fill");
        cycle(1'b0, 1'b1, 8'h80, "s3_jump");
        chk("s3_drop", 16'(byte_valid), 16'h0);
        cycle(1'b0, 1'b0, 8'h00, "s3_j1");
        cycle(1'b0, 1'b0, 8'h00, "s3_j2");
        chk("s3_addr", 16'(byte_addr), 16'h80);
        chk("s3_data", 16'(byte_out), 16'hDA);
        repeat (3) cycle(1'b1, 1'b0, 8'h00, "s3_run");

        // 4: wrap-around from FE
        cycle(1'b1, 1'b1, 8'hFE, "s4_jump");
        repeat (6) cycle(1'b1, 1'b0, 8'h00, "s4_run");

        // 5: jump during pop, then a second jump to 20
        cycle(1'b1, 1'b1, 8'h40, "s5_j1");
        cycle(1'b1, 1'b1, 8'h20, "s5_j2");
        cycle(1'b1, 1'b0, 8'h00, "s5_w1");
        cycle(1'b1, 1'b0, 8'h00, "s5_w2");
        chk("s5_addr", 16'(byte_addr), 16'h20);
        chk("s5_data", 16'(byte_out), 16'h7A);
        repeat (3) cycle(1'b1, 1'b0, 8'h00, "s5_run");

        // 6: asynchronous reset mid-stream
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_valid", 16'(byte_valid), 16'h0);
        chk("s6_out", 16'(byte_out), 16'h0);
        chk("s6_baddr", 16'(byte_addr), 16'h0);
        repeat (2) @(negedge clk);
        rst_n         = 1'b1;
        exp_addr      = 8'h00;
        since_restart = 0;
        cycle(1'b1, 1'b0, 8'h00, "s6_e1");
        cycle(1'b1, 1'b0, 8'h00, "s6_e2");
        chk("s6_first_addr", 16'(byte_addr), 16'h00);
        repeat (3) cycle(1'b1, 1'b0, 8'h00, "s6_run");

        // Random READY / JUMP traffic
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            logic jmp;
            rdy = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 15) == 0);
            cycle(rdy, jmp, 8'($urandom), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
